// File: rtl/axis_rr_arbiter_ctrl.sv
// axis_rr_arbiter_ctrl: round-robin arbiter that shares one valid/ready stream port
// between N AXI-stream initiators, in front of the elastic buffer controller.
// Optional feature macro: ARB_PKT_LOCK_EN
//   defined   -> the grant is held for a whole packet and released on a last-beat handshake
//   undefined -> every handshake releases the grant (per-beat arbitration)
module axis_rr_arbiter_ctrl #(
    parameter int unsigned N      = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N-1:0]        s_valid,
    output logic [N-1:0]        s_ready,
    input  logic [N-1:0]        s_last,
    input  logic [N*DATA_W-1:0] s_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_last,
    output logic [DATA_W-1:0]   m_data,
    output logic [N-1:0]        gnt,
    output logic [IDX_W-1:0]    gnt_idx,
    output logic                busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       gnt_q, gnt_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [N-1:0]       win_oh;
    logic [IDX_W-1:0]   win_idx;
    logic               win_any;
    logic               hs;
    logic               release_gnt;

    logic [DATA_W-1:0]  s_data_arr [N];

    // Unpack the flattened payload into one lane per requester
    for (genvar g = 0; g < N; g++) begin : g_lane
        assign s_data_arr[g] = s_data[g*DATA_W +: DATA_W];
    end

    // Datapath driven purely from the registered grant; zero grant gives all-quiet outputs
    always_comb begin
        s_ready = gnt_q & {N{m_ready}};
        m_valid = |(gnt_q & s_valid);
        m_last  = |(gnt_q & s_last);
        m_data  = '0;
        if (state_q == LOCKED) begin
            m_data = s_data_arr[gnt_idx_q];
        end
    end

    assign hs = m_valid & m_ready;

`ifdef ARB_PKT_LOCK_EN
    assign release_gnt = hs & m_last;
`else
    assign release_gnt = hs;
`endif

    // Round-robin search: first valid requester starting one past the last winner, wrapping
    always_comb begin
        int unsigned cand;
        win_oh  = '0;
        win_idx = '0;
        win_any = 1'b0;
        cand    = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = (32'(rr_ptr_q) + k) % N;
            if (!win_any && s_valid[IDX_W'(cand)]) begin
                win_any                = 1'b1;
                win_idx                = IDX_W'(cand);
                win_oh[IDX_W'(cand)]   = 1'b1;
            end
        end
    end

    // Next-state: grant on any request in IDLE, release on the qualifying handshake
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        rr_ptr_d  = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    state_d   = LOCKED;
                    gnt_d     = win_oh;
                    gnt_idx_d = win_idx;
                    rr_ptr_d  = win_idx;
                end
            end
            LOCKED: begin
                if (release_gnt) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State and grant registers; pointer resets to N-1 so requester 0 wins first
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            rr_ptr_q  <= IDX_W'(N - 1);
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign busy    = (state_q == LOCKED);

endmodule

// File: tb/tb_axis_rr_arbiter_ctrl.sv
// Self-checking bench for axis_rr_arbiter_ctrl (N=4, DATA_W=32).
// Common vectors use single-beat packets so they hold with or without ARB_PKT_LOCK_EN;
// a mode-specific table covers packet lock or per-beat interleave.
module tb_axis_rr_arbiter_ctrl;

    localparam int unsigned N      = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 2;

    logic                clk;
    logic                reset_n;
    logic [N-1:0]        s_valid;
    logic [N-1:0]        s_ready;
    logic [N-1:0]        s_last;
    logic [N*DATA_W-1:0] s_data;
    logic                m_valid;
    logic                m_ready;
    logic                m_last;
    logic [DATA_W-1:0]   m_data;
    logic [N-1:0]        gnt;
    logic [IDX_W-1:0]    gnt_idx;
    logic                busy;

    int total;
    int bad;
    int row;

    typedef struct {
        logic [3:0] sv;
        logic [3:0] sl;
        logic       mr;
        logic [7:0] beat;
        logic [3:0] egnt;
        logic [1:0] eidx;
        logic       ebusy;
        logic       emv;
        logic [3:0] esr;
    } vec_t;

    vec_t tbl[$];

    axis_rr_arbiter_ctrl #(
        .N      (N),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_last  (s_last),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_last  (m_last),
        .m_data  (m_data),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int i, input logic [7:0] b);
        return 32'hC0DE_0000 | (32'(i) << 8) | 32'(b);
    endfunction

    function automatic vec_t mk(input logic [3:0] sv, input logic [3:0] sl, input logic mr,
                                input logic [7:0] beat, input logic [3:0] egnt,
                                input logic [1:0] eidx, input logic ebusy, input logic emv,
                                input logic [3:0] esr);
        vec_t v;
        v.sv = sv; v.sl = sl; v.mr = mr; v.beat = beat;
        v.egnt = egnt; v.eidx = eidx; v.ebusy = ebusy; v.emv = emv; v.esr = esr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s row=%0d actual=%h expected=%h", nm, row, act, exp_v);
        end
    endtask

    task automatic drive_data(input logic [7:0] beat);
        for (int i = 0; i < N; i++) s_data[i*DATA_W +: DATA_W] = pat(i, beat);
    endtask

    // Drive one row after the falling edge, then check before the next rising edge
    task automatic apply(input vec_t v);
        logic [31:0] exp_data;
        logic        exp_last;
        @(negedge clk);
        s_valid = v.sv;
        s_last  = v.sl;
        m_ready = v.mr;
        drive_data(v.beat);
        #1;
        exp_last = (v.egnt != 4'd0) ? v.sl[v.eidx] : 1'b0;
        exp_data = (v.egnt != 4'd0) ? pat(int'(v.eidx), v.beat) : 32'd0;
        chk("gnt",     32'(gnt),     32'(v.egnt));
        chk("gnt_idx", 32'(gnt_idx), 32'(v.eidx));
        chk("busy",    32'(busy),    32'(v.ebusy));
        chk("m_valid", 32'(m_valid), 32'(v.emv));
        chk("s_ready", 32'(s_ready), 32'(v.esr));
        chk("m_last",  32'(m_last),  32'(exp_last));
        chk("m_data",  m_data,       exp_data);
        row++;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        row     = 0;
        reset_n = 1'b0;
        s_valid = 4'hF;
        s_last  = 4'hF;
        m_ready = 1'b1;
        s_data  = '0;
        drive_data(8'h00);

        // Reset held with every requester asking
        repeat (3) @(negedge clk);
        #1;
        chk("rst_gnt",     32'(gnt),     32'd0);
        chk("rst_gnt_idx", 32'(gnt_idx), 32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_m_data",  m_data,       32'd0);
        reset_n = 1'b1;

        // Rotation, backpressure, single requester, wrap, gaps (single-beat packets)
        tbl.push_back(mk(4'hF, 4'hF, 1'b1, 8'h01, 4'h1, 2'd0, 1'b1, 1'b1, 4'h1));
        tbl.push_back(mk(4'hF, 4'hF, 1'b1, 8'h02, 4'h0, 2'd0, 1'b0, 1'b0, 4'h0));
        tbl.push_back(mk(4'hF, 4'hF, 1'b1, 8'h03, 4'h2, 2'd1, 1'b1, 1'b1, 4'h2));
        tbl.push_back(mk(4'hF, 4'hF, 1'b1, 8'h04, 4'h0, 2'd1, 1'b0, 1'b0, 4'h0));
        tbl.push_back(mk(4'hF, 4'hF, 1'b1, 8'h05, 4'h4, 2'd2, 1'b1, 1'b1, 4'h4));
        tbl.push_back(mk(4'hF, 4'hF, 1'b1, 8'h06, 4'h0, 2'd2, 1'b0, 1'b0, 4'h0));
        tbl.push_back(mk(4'hF, 4'hF, 1'b1, 8'h07, 4'h8, 2'd3, 1'b1, 1'b1, 4'h8));
        tbl.push_back(mk(4'hF, 4'hF, 1'b1, 8'h08, 4'h0, 2'd3, 1'b0, 1'b0, 4'h0));
        tbl.push_back(mk(4'hF, 4'hF, 1'b0, 8'h09, 4'h1, 2'd0, 1'b1, 1'b1, 4'h0));
        tbl.push_back(mk(4'hF, 4'hF, 1'b0, 8'h09, 4'h1, 2'd0, 1'b1, 1'b1, 4'h0));
        tbl.push_back(mk(4'hF, 4'hF, 1'b1, 8'h09, 4'h1, 2'd0, 1'b1, 1'b1, 4'h1));
        tbl.push_back(mk(4'h0, 4'hF, 1'b1, 8'h0C, 4'h0, 2'd0, 1'b0, 1'b0, 4'h0));
        tbl.push_back(mk(4'h0, 4'hF, 1'b1, 8'h0D, 4'h0, 2'd0, 1'b0, 1'b0, 4'h0));
        tbl.push_back(mk(4'h1, 4'hF, 1'b1, 8'h0E, 4'h0, 2'd0, 1'b0, 1'b0, 4'h0));
        tbl.push_back(mk(4'h1, 4'hF, 1'b1, 8'h0F, 4'h1, 2'd0, 1'b1, 1'b1, 4'h1));
        tbl.push_back(mk(4'h9, 4'hF, 1'b1, 8'h10, 4'h0, 2'd0, 1'b0, 1'b0, 4'h0));
        tbl.push_back(mk(4'h9, 4'hF, 1'b1, 8'h11, 4'h8, 2'd3, 1'b1, 1'b1, 4'h8));
        tbl.push_back(mk(4'h9, 4'hF, 1'b1, 8'h12, 4'h0, 2'd3, 1'b0, 1'b0, 4'h0));
        tbl.push_back(mk(4'h9, 4'hF, 1'b1, 8'h13, 4'h1, 2'd0, 1'b1, 1'b1, 4'h1));
        tbl.push_back(mk(4'h4, 4'hF, 1'b0, 8'h14, 4'h0, 2'd0, 1'b0, 1'b0, 4'h0));
        tbl.push_back(mk(4'h0, 4'hF, 1'b1, 8'h15, 4'h4, 2'd2, 1'b1, 1'b0, 4'h4));
        tbl.push_back(mk(4'h6, 4'hF, 1'b1, 8'h16, 4'h4, 2'd2, 1'b1, 1'b1, 4'h4));
        tbl.push_back(mk(4'h2, 4'hF, 1'b1, 8'h17, 4'h0, 2'd2, 1'b0, 1'b0, 4'h0));
        tbl.push_back(mk(4'h2, 4'hF, 1'b1, 8'h18, 4'h2, 2'd1, 1'b1, 1'b1, 4'h2));
        tbl.push_back(mk(4'h0, 4'hF, 1'b1, 8'h19, 4'h0, 2'd1, 1'b0, 1'b0, 4'h0));

`ifdef ARB_PKT_LOCK_EN
        // Multi-beat packet with a two-cycle gap while requester 3 waits
        tbl.push_back(mk(4'h2, 4'h0, 1'b1, 8'h20, 4'h0, 2'd1, 1'b0, 1'b0, 4'h0));
        tbl.push_back(mk(4'hA, 4'h0, 1'b1, 8'h21, 4'h2, 2'd1, 1'b1, 1'b1, 4'h2));
        tbl.push_back(mk(4'h8, 4'h0, 1'b1, 8'h22, 4'h2, 2'd1, 1'b1, 1'b0, 4'h2));
        tbl.push_back(mk(4'h8, 4'h0, 1'b1, 8'h23, 4'h2, 2'd1, 1'b1, 1'b0, 4'h2));
        tbl.push_back(mk(4'hA, 4'h2, 1'b1, 8'h24, 4'h2, 2'd1, 1'b1, 1'b1, 4'h2));
        tbl.push_back(mk(4'h8, 4'h8, 1'b1, 8'h25, 4'h0, 2'd1, 1'b0, 1'b0, 4'h0));
        tbl.push_back(mk(4'h8, 4'h8, 1'b0, 8'h26, 4'h8, 2'd3, 1'b1, 1'b1, 4'h0));
        tbl.push_back(mk(4'h8, 4'h8, 1'b1, 8'h26, 4'h8, 2'd3, 1'b1, 1'b1, 4'h8));
        tbl.push_back(mk(4'h0, 4'h0, 1'b1, 8'h27, 4'h0, 2'd3, 1'b0, 1'b0, 4'h0));
`else
        // Per-beat arbitration: two 3-beat packets interleave 0,1,0,1,0,1
        tbl.push_back(mk(4'h3, 4'h0, 1'b1, 8'h30, 4'h0, 2'd1, 1'b0, 1'b0, 4'h0));
        tbl.push_back(mk(4'h3, 4'h0, 1'b1, 8'h31, 4'h1, 2'd0, 1'b1, 1'b1, 4'h1));
        tbl.push_back(mk(4'h3, 4'h0, 1'b1, 8'h32, 4'h0, 2'd0, 1'b0, 1'b0, 4'h0));
        tbl.push_back(mk(4'h3, 4'h0, 1'b1, 8'h33, 4'h2, 2'd1, 1'b1, 1'b1, 4'h2));
        tbl.push_back(mk(4'h3, 4'h0, 1'b1, 8'h34, 4'h0, 2'd1, 1'b0, 1'b0, 4'h0));
        tbl.push_back(mk(4'h3, 4'h0, 1'b1, 8'h35, 4'h1, 2'd0, 1'b1, 1'b1, 4'h1));
        tbl.push_back(mk(4'h3, 4'h0, 1'b1, 8'h36, 4'h0, 2'd0, 1'b0, 1'b0, 4'h0));
        tbl.push_back(mk(4'h3, 4'h0, 1'b1, 8'h37, 4'h2, 2'd1, 1'b1, 1'b1, 4'h2));
        tbl.push_back(mk(4'h3, 4'h3, 1'b1, 8'h38, 4'h0, 2'd1, 1'b0, 1'b0, 4'h0));
        tbl.push_back(mk(4'h3, 4'h3, 1'b1, 8'h39, 4'h1, 2'd0, 1'b1, 1'b1, 4'h1));
        tbl.push_back(mk(4'h3, 4'h3, 1'b1, 8'h3A, 4'h0, 2'd0, 1'b0, 1'b0, 4'h0));
        tbl.push_back(mk(4'h3, 4'h3, 1'b1, 8'h3B, 4'h2, 2'd1, 1'b1, 1'b1, 4'h2));
        tbl.push_back(mk(4'h0, 4'h0, 1'b1, 8'h3C, 4'h0, 2'd1, 1'b0, 1'b0, 4'h0));
`endif

        foreach (tbl[i]) apply(tbl[i]);

        // Asynchronous reset in the middle of a stalled packet
        @(negedge clk);
        s_valid = 4'h4;
        s_last  = 4'h0;
        m_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_gnt",  32'(gnt),  32'h4);
        m_ready = 1'b1;
        #1;
        chk("mid_s_ready", 32'(s_ready), 32'h4);
        reset_n = 1'b0;
        #1;
        chk("arst_gnt",     32'(gnt),     32'd0);
        chk("arst_busy",    32'(busy),    32'd0);
        chk("arst_m_valid", 32'(m_valid), 32'd0);
        chk("arst_s_ready", 32'(s_ready), 32'd0);
        chk("arst_m_data",  m_data,       32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_gnt", 32'(gnt), 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
